me_unit: RTL

Memory-stage pipeline unit of the five-stage LoongArch core, sitting between the execute stage and the writeback stage. It consumes the 131-bit execute-to-memory bus and the synchronous data SRAM read data. It captures and holds load data across writeback stalls, aligns and extends byte, half and word loads, and forwards the result, destination and CSR write information to earlier stages. It carries exception and ertn status down to writeback unchanged and squashes itself on pipeline flush.

---
 rtl/me_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/me_unit.sv
// Memory stage of the five-stage LoongArch pipeline: captures SRAM load data across
// writeback stalls, aligns/extends loads and forwards results to earlier stages.
module me_unit (
  input  logic         clk,
  input  logic         reset,
  input  logic         ex_to_me_valid,
  input  logic [130:0] ex_to_me_bus,
  output logic         me_allow_in,
  input  logic [31:0]  data_sram_rdata,
  output logic         me_to_wb_valid,
  input  logic         wb_allow_in,
  output logic [124:0] me_to_wb_bus,
  output logic [4:0]   me_dest,
  output logic [31:0]  me_forward_res,
  output logic         me_sys_op,
  output logic [46:0]  me_to_ex_bus,
  input  logic         excp_flush,
  input  logic         ertn_flush
);

  typedef struct packed {
    logic        excp_en;
    logic [5:0]  excp_num;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic        ld_signed;
    logic        ld_byte;
    logic        ld_half;
    logic [1:0]  addr_off;
    logic [31:0] pc;
    logic [31:0] ex_result;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
  } ex_bus_t;

  ex_bus_t     pl;
  logic        me_valid;
  logic        hold_vld;
  logic [31:0] hold;
  logic        flush;
  logic        load_en;
  logic [31:0] load_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] final_result;

  // ready_go is always 1, so the stage frees up whenever writeback takes the instruction.
  assign flush          = excp_flush | ertn_flush;
  assign me_allow_in    = !me_valid | wb_allow_in;
  assign me_to_wb_valid = me_valid;
  assign load_en        = me_allow_in & ex_to_me_valid & !flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation results.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      me_valid <= 1'b0;
    end else if (me_allow_in) begin
      me_valid <= ex_to_me_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pl <= '0;
    end else if (load_en) begin
      pl <= ex_bus_t'(ex_to_me_bus);
    end
  end

  // SRAM data is only valid in the first occupied cycle; keep it while writeback stalls.
  always_ff @(posedge clk) begin
    if (reset || flush || load_en) begin
      hold_vld <= 1'b0;
    end else if (me_valid && pl.res_from_mem && !hold_vld && !wb_allow_in) begin
      hold_vld <= 1'b1;
    end
  end

  // NOTE: the hold data register has no reset; it is never observed unless hold_vld is set.
  always_ff @(posedge clk) begin
    if (me_valid && pl.res_from_mem && !hold_vld && !wb_allow_in) begin
      hold <= data_sram_rdata;
    end
  end

  assign load_word = hold_vld ? hold : data_sram_rdata;
  assign byte_sel  = load_word[8*pl.addr_off +: 8];
  assign half_sel  = pl.addr_off[1] ? load_word[31:16] : load_word[15:0];

  // NOTE: load_ext gets a default first so no path through the block leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    load_ext = load_word;
    if (pl.ld_byte) begin
      load_ext = {{24{pl.ld_signed & byte_sel[7]}}, byte_sel};
    end else if (pl.ld_half) begin
      load_ext = {{16{pl.ld_signed & half_sel[15]}}, half_sel};
    end
  end

  // On an address-misaligned exception ex_result carries the faulting address.
  assign final_result   = (pl.res_from_mem && !pl.excp_en) ? load_ext : pl.ex_result;
  assign me_forward_res = final_result;

  assign me_to_wb_bus = {pl.excp_en,
                         pl.excp_num,
                         pl.csr_num,
                         pl.csr_we & !pl.excp_en,
                         pl.csr_wvalue,
                         pl.ertn,
                         pl.pc,
                         final_result,
                         pl.gr_we & !pl.excp_en,
                         pl.dest};

  assign me_dest      = pl.dest & {5{pl.gr_we & me_valid}};
  assign me_sys_op    = me_valid & (pl.excp_en | pl.ertn);
  assign me_to_ex_bus = {pl.csr_num, pl.csr_we & me_valid, pl.csr_wvalue};

endmodule
